// File: rtl/psram_pkg.sv
// Shared definitions for the asynchronous PSRAM controller: FSM encoding,
// bus widths, the pin levels used while the chip is deselected, and the wait-counter load.
package psram_pkg;

   localparam int PSRAM_AW = 23;
   localparam int PSRAM_DW = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETUP   = 2'd1,
      ST_ACCESS  = 2'd2,
      ST_RECOVER = 2'd3
   } psram_state_t;

   localparam logic                IDLE_CE   = 1'b1;
   localparam logic                IDLE_OE   = 1'b1;
   localparam logic                IDLE_WE   = 1'b1;
   localparam logic                IDLE_UB   = 1'b1;
   localparam logic                IDLE_LB   = 1'b1;
   localparam logic [PSRAM_AW-1:0] IDLE_ADDR = '0;

   // The wait counter counts down to zero, so a phase of N cycles loads N-1.
   function automatic logic [3:0] wait_load(input int cyc);
      return 4'(cyc - 1);
   endfunction

endpackage

// File: rtl/psram_rr_arb.sv
// Two-way round-robin arbiter: on a tie the port not served last wins;
// after reset port 0 has priority.
module psram_rr_arb (
   input  logic       clk,
   input  logic       clr,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt_onehot
);

   // 1 means port 1 was served last, so port 0 wins the next tie.
   logic r_last;

   always_comb begin
      gnt_onehot = 2'b00;
      if (req == 2'b11)
         gnt_onehot = r_last ? 2'b01 : 2'b10;
      else if (req[0])
         gnt_onehot = 2'b01;
      else if (req[1])
         gnt_onehot = 2'b10;
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr)
         r_last <= 1'b1;
      else if (advance && (gnt_onehot != 2'b00))
         r_last <= gnt_onehot[1];
   end

endmodule

// File: rtl/psram_async_ctrl.sv
// Two-port arbiter and access sequencer for an asynchronous-mode PSRAM.
// All pin outputs are registered; the data bus is tristated outside write windows.
module psram_async_ctrl
   import psram_pkg::*;
#(
   parameter int ACCESS_CYC = 7,
   parameter int REC_CYC    = 2
) (
   input  logic                clk,
   input  logic                clr,
   input  logic [1:0]          req,
   input  logic [1:0]          wr,
   input  logic [1:0]          be0,
   input  logic [1:0]          be1,
   input  logic [PSRAM_AW-1:0] addr0,
   input  logic [PSRAM_AW-1:0] addr1,
   input  logic [PSRAM_DW-1:0] wdata0,
   input  logic [PSRAM_DW-1:0] wdata1,
   output logic [1:0]          ack,
   output logic [1:0]          done,
   output logic [PSRAM_DW-1:0] rdata,
   output logic [PSRAM_AW-1:0] ram_addr,
   inout  wire  [PSRAM_DW-1:0] ram_data,
   output logic                ram_ce,
   output logic                ram_oe,
   output logic                ram_we,
   output logic                ram_ub,
   output logic                ram_lb,
   output logic                ram_adv,
   output logic                ram_cre,
   output logic                ram_clk
);

   localparam logic [3:0] WAIT_ACC = wait_load(ACCESS_CYC);
   localparam logic [3:0] WAIT_REC = wait_load(REC_CYC);

   psram_state_t        r_state;
   logic [3:0]          r_wait;
   logic [1:0]          r_ack;
   logic [1:0]          r_done;
   logic [PSRAM_DW-1:0] r_rdata;
   logic [PSRAM_AW-1:0] r_addr;
   logic [PSRAM_DW-1:0] r_wdata;
   logic                r_ce;
   logic                r_oe;
   logic                r_we;
   logic                r_ub;
   logic                r_lb;
   logic                r_drive;
   logic                r_port;
   logic                r_wr;

   logic [1:0]          w_gnt;
   logic                w_sel;
   logic                w_wr_sel;
   logic [1:0]          w_be_sel;
   logic [PSRAM_AW-1:0] w_addr_sel;
   logic [PSRAM_DW-1:0] w_wdata_sel;
   logic [1:0]          w_port_onehot;
   logic                w_advance;

   assign w_advance = (r_state == ST_IDLE);

   psram_rr_arb u_arb (
      .clk        (clk),
      .clr        (clr),
      .req        (req),
      .advance    (w_advance),
      .gnt_onehot (w_gnt)
   );

   assign w_sel         = w_gnt[1];
   assign w_wr_sel      = w_sel ? wr[1]  : wr[0];
   assign w_be_sel      = w_sel ? be1    : be0;
   assign w_addr_sel    = w_sel ? addr1  : addr0;
   assign w_wdata_sel   = w_sel ? wdata1 : wdata0;
   assign w_port_onehot = r_port ? 2'b10 : 2'b01;

   // Sequencer: pins are updated on the same edge as the state they belong to.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state <= ST_IDLE;
         r_wait  <= 4'd0;
         r_ack   <= 2'b00;
         r_done  <= 2'b00;
         r_rdata <= '0;
         r_addr  <= IDLE_ADDR;
         r_ce    <= IDLE_CE;
         r_oe    <= IDLE_OE;
         r_we    <= IDLE_WE;
         r_ub    <= IDLE_UB;
         r_lb    <= IDLE_LB;
         r_drive <= 1'b0;
         r_port  <= 1'b0;
         r_wr    <= 1'b0;
      end else begin
         r_ack  <= 2'b00;
         r_done <= 2'b00;
         case (r_state)
            ST_IDLE: begin
               if (w_gnt != 2'b00) begin
                  r_state <= ST_SETUP;
                  r_ack   <= w_gnt;
                  r_port  <= w_sel;
                  r_wr    <= w_wr_sel;
                  r_addr  <= w_addr_sel;
                  r_ce    <= 1'b0;
                  r_oe    <= 1'b1;
                  r_we    <= 1'b1;
                  r_ub    <= ~w_be_sel[1];
                  r_lb    <= ~w_be_sel[0];
                  r_drive <= w_wr_sel;
               end
            end
            ST_SETUP: begin
               r_state <= ST_ACCESS;
               r_wait  <= WAIT_ACC;
               r_we    <= ~r_wr;
               r_oe    <= r_wr;
            end
            ST_ACCESS: begin
               if (r_wait == 4'd0) begin
                  r_state <= ST_RECOVER;
                  r_wait  <= WAIT_REC;
                  r_ce    <= 1'b1;
                  r_we    <= 1'b1;
                  r_oe    <= 1'b1;
                  if (!r_wr)
                     r_rdata <= ram_data;
               end else begin
                  r_wait <= r_wait - 4'd1;
               end
            end
            ST_RECOVER: begin
               // Address and write data were held through the first recovery cycle only.
               r_drive <= 1'b0;
               r_addr  <= IDLE_ADDR;
               if (r_wait == 4'd0) begin
                  r_state <= ST_IDLE;
                  r_done  <= w_port_onehot;
                  r_ub    <= IDLE_UB;
                  r_lb    <= IDLE_LB;
               end else begin
                  r_wait <= r_wait - 4'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if ((r_state == ST_IDLE) && (w_gnt != 2'b00))
         r_wdata <= w_wdata_sel;
   end

   assign ram_data = r_drive ? r_wdata : {PSRAM_DW{1'bz}};

   assign ack      = r_ack;
   assign done     = r_done;
   assign rdata    = r_rdata;
   assign ram_addr = r_addr;
   assign ram_ce   = r_ce;
   assign ram_oe   = r_oe;
   assign ram_we   = r_we;
   assign ram_ub   = r_ub;
   assign ram_lb   = r_lb;
   assign ram_adv  = 1'b0;
   assign ram_cre  = 1'b0;
   assign ram_clk  = 1'b0;

endmodule

// File: tb/tb_psram_async_ctrl.sv
// Directed bench for psram_async_ctrl with a behavioural asynchronous PSRAM model,
// plus a second instance at the minimum timing parameters.
module tb_psram_async_ctrl;

   logic        clk = 1'b0;
   logic        clr;
   logic [1:0]  req, wr, be0, be1;
   logic [22:0] addr0, addr1;
   logic [15:0] wdata0, wdata1;
   logic [1:0]  ack, done;
   logic [15:0] rdata;
   logic [22:0] ram_addr;
   wire  [15:0] ram_data;
   logic        ram_ce, ram_oe, ram_we, ram_ub, ram_lb, ram_adv, ram_cre, ram_clk;

   logic [1:0]  f_req;
   logic [1:0]  f_ack, f_done;
   logic [15:0] f_rdata;
   logic [22:0] f_ram_addr;
   wire  [15:0] f_ram_data;
   logic        f_ce, f_oe, f_we, f_ub, f_lb, f_adv, f_cre, f_rclk;

   int n_chk = 0;
   int n_err = 0;

   logic [15:0] mem [0:255];

   always #5 clk = ~clk;

   psram_async_ctrl dut (
      .clk(clk), .clr(clr), .req(req), .wr(wr), .be0(be0), .be1(be1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack(ack), .done(done), .rdata(rdata), .ram_addr(ram_addr), .ram_data(ram_data),
      .ram_ce(ram_ce), .ram_oe(ram_oe), .ram_we(ram_we), .ram_ub(ram_ub), .ram_lb(ram_lb),
      .ram_adv(ram_adv), .ram_cre(ram_cre), .ram_clk(ram_clk)
   );

   psram_async_ctrl #(.ACCESS_CYC(1), .REC_CYC(1)) dut_fast (
      .clk(clk), .clr(clr), .req(f_req), .wr(2'b00), .be0(2'b11), .be1(2'b11),
      .addr0(23'h000004), .addr1(23'h000000), .wdata0(16'h0000), .wdata1(16'h0000),
      .ack(f_ack), .done(f_done), .rdata(f_rdata), .ram_addr(f_ram_addr), .ram_data(f_ram_data),
      .ram_ce(f_ce), .ram_oe(f_oe), .ram_we(f_we), .ram_ub(f_ub), .ram_lb(f_lb),
      .ram_adv(f_adv), .ram_cre(f_cre), .ram_clk(f_rclk)
   );

   // PSRAM model: reads drive the bus while CE#/OE# are low, writes land per byte lane.
   assign ram_data   = (!ram_ce && !ram_oe) ? mem[ram_addr[7:0]] : 16'hzzzz;
   assign f_ram_data = (!f_ce && !f_oe) ? 16'hC35A : 16'hzzzz;

   always @(negedge clk) begin
      if (!ram_ce && !ram_we) begin
         if (!ram_lb) mem[ram_addr[7:0]][7:0]  <= ram_data[7:0];
         if (!ram_ub) mem[ram_addr[7:0]][15:8] <= ram_data[15:8];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic released(input logic [15:0] v);
      return (v === 16'hzzzz) || (v === 16'h0000);
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One single-word access on port p; reports timing and pin observations.
   task automatic do_access(input int p, input logic w, input logic [1:0] b,
                            input logic [22:0] a, input logic [15:0] d,
                            output int ack_at, output int done_at, output int we_lo,
                            output int oe_lo, output int match_cnt, output int busy_cnt,
                            output logic [15:0] rd, output logic ub_s, output logic lb_s,
                            output logic [22:0] addr_s);
      ack_at = -1; done_at = -1; we_lo = 0; oe_lo = 0; match_cnt = 0; busy_cnt = 0;
      rd = 16'h0; ub_s = 1'b1; lb_s = 1'b1; addr_s = 23'h0;
      if (p == 0) begin
         wr[0] = w; be0 = b; addr0 = a; wdata0 = d;
      end else begin
         wr[1] = w; be1 = b; addr1 = a; wdata1 = d;
      end
      req[p] = 1'b1;
      for (int k = 1; k <= 40 && done_at < 0; k++) begin
         tick();
         if (ack[p]) begin
            ack_at = k;
            addr_s = ram_addr;
            req[p] = 1'b0;
         end
         if (!ram_we) we_lo++;
         if (!ram_oe) oe_lo++;
         if (!ram_we || !ram_oe) begin
            ub_s = ram_ub;
            lb_s = ram_lb;
         end
         if (ram_data === d) match_cnt++;
         if (ram_oe && !released(ram_data)) busy_cnt++;
         if (done[p]) begin
            done_at = k;
            rd = rdata;
         end
      end
      req[p] = 1'b0;
   endtask

   int          a_at, d_at, we_lo, oe_lo, m_cnt, b_cnt;
   logic [15:0] rd;
   logic        ub_s, lb_s;
   logic [22:0] a_s;
   int          gnt_seq [4];
   int          ack_k [4];
   int          acks, k, dn;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      clr = 1'b1; req = 2'b00; wr = 2'b00; be0 = 2'b11; be1 = 2'b11;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; f_req = 2'b00;
      tick(); tick();

      chk("rst_ce", ram_ce, 1'b1);
      chk("rst_oe", ram_oe, 1'b1);
      chk("rst_we", ram_we, 1'b1);
      chk("rst_ub", ram_ub, 1'b1);
      chk("rst_lb", ram_lb, 1'b1);
      chk("rst_addr", ram_addr, 23'h0);
      chk("rst_ack", ack, 2'b00);
      chk("rst_done", done, 2'b00);
      chk("rst_rdata", rdata, 16'h0);
      chk("rst_bus", released(ram_data), 1'b1);
      chk("const_pins", {ram_adv, ram_cre, ram_clk}, 3'b000);
      clr = 1'b0;
      tick();

      // Port 0 full-word write.
      do_access(0, 1'b1, 2'b11, 23'h000010, 16'hAB03, a_at, d_at, we_lo, oe_lo, m_cnt, b_cnt, rd, ub_s, lb_s, a_s);
      chk("wr_ack_lat", a_at, 1);
      chk("wr_done_ofs", d_at - a_at, 10);
      chk("wr_we_low", we_lo, 7);
      chk("wr_oe_low", oe_lo, 0);
      chk("wr_data_cyc", m_cnt, 9);
      chk("wr_drive_cyc", b_cnt, 9);
      chk("wr_addr", a_s, 23'h000010);
      chk("wr_mem", mem[8'h10], 16'hAB03);

      // Port 1 read of the same word.
      do_access(1, 1'b0, 2'b11, 23'h000010, 16'h0000, a_at, d_at, we_lo, oe_lo, m_cnt, b_cnt, rd, ub_s, lb_s, a_s);
      chk("rd_ack_lat", a_at, 1);
      chk("rd_done_ofs", d_at - a_at, 10);
      chk("rd_oe_low", oe_lo, 7);
      chk("rd_we_low", we_lo, 0);
      chk("rd_no_drive", b_cnt, 0);
      chk("rd_data", rd, 16'hAB03);

      // Lower-byte-only write, then read back through port 1.
      do_access(0, 1'b1, 2'b01, 23'h000010, 16'h77CC, a_at, d_at, we_lo, oe_lo, m_cnt, b_cnt, rd, ub_s, lb_s, a_s);
      chk("be01_lb", lb_s, 1'b0);
      chk("be01_ub", ub_s, 1'b1);
      chk("be01_mem", mem[8'h10], 16'hABCC);
      do_access(1, 1'b0, 2'b11, 23'h000010, 16'h0000, a_at, d_at, we_lo, oe_lo, m_cnt, b_cnt, rd, ub_s, lb_s, a_s);
      chk("be01_rdback", rd, 16'hABCC);

      // Both ports requesting continuously.
      wr = 2'b00; addr0 = 23'h000010; addr1 = 23'h000010;
      req = 2'b11; acks = 0; k = 0;
      while (acks < 4 && k < 80) begin
         tick(); k++;
         if (ack != 2'b00) begin
            gnt_seq[acks] = ack[1] ? 1 : 0;
            ack_k[acks] = k;
            acks++;
            if (acks == 4) req = 2'b00;
         end
      end
      req = 2'b00;
      chk("rr_count", acks, 4);
      chk("rr_gnt0", gnt_seq[0], 0);
      chk("rr_gnt1", gnt_seq[1], 1);
      chk("rr_gnt2", gnt_seq[2], 0);
      chk("rr_gnt3", gnt_seq[3], 1);
      chk("rr_gap01", ack_k[1] - ack_k[0], 11);
      chk("rr_gap12", ack_k[2] - ack_k[1], 11);
      chk("rr_gap23", ack_k[3] - ack_k[2], 11);
      for (int j = 0; j < 12; j++) tick();

      // Reset pulsed in the middle of a write's access phase.
      wr = 2'b01; be0 = 2'b11; addr0 = 23'h000020; wdata0 = 16'h1111;
      req = 2'b01; k = 0; a_at = -1;
      while (a_at < 0 && k < 5) begin
         tick(); k++;
         if (ack[0]) a_at = k;
      end
      req = 2'b00;
      chk("clr_ack", a_at, 1);
      tick(); tick(); tick();
      chk("clr_pre_we", ram_we, 1'b0);
      clr = 1'b1;
      #1;
      chk("clr_async_we", ram_we, 1'b1);
      chk("clr_async_ce", ram_ce, 1'b1);
      chk("clr_async_bus", released(ram_data), 1'b1);
      #1 clr = 1'b0;
      dn = 0;
      for (int j = 0; j < 15; j++) begin
         tick();
         if (done != 2'b00) dn++;
      end
      chk("clr_no_done", dn, 0);
      wr = 2'b00; addr1 = 23'h000010;
      req = 2'b11; k = 0; a_at = -1;
      while (a_at < 0 && k < 5) begin
         tick(); k++;
         if (ack != 2'b00) begin
            a_at = k;
            chk("clr_next_gnt", ack, 2'b01);
         end
      end
      req = 2'b00;
      chk("clr_next_ack", a_at, 1);
      for (int j = 0; j < 12; j++) tick();

      // Minimum timing instance: single read.
      f_req = 2'b01; a_at = -1; d_at = -1; oe_lo = 0;
      for (int j = 1; j <= 20 && d_at < 0; j++) begin
         tick();
         if (f_ack[0]) begin a_at = j; f_req = 2'b00; end
         if (!f_oe) oe_lo++;
         if (f_done[0]) begin d_at = j; rd = f_rdata; end
      end
      f_req = 2'b00;
      chk("fast_ack", a_at, 1);
      chk("fast_done_ofs", d_at - a_at, 3);
      chk("fast_oe_low", oe_lo, 1);
      chk("fast_rdata", rd, 16'hC35A);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/psram_async_ctrl.md
# psram_async_ctrl

Two-port arbiter and access sequencer for the board's asynchronous-mode PSRAM (23-bit word address, 16-bit data). It replaces direct pin driving from the application logic. It accepts single-word read/write requests from two requesters, shares the chip between them round-robin, and generates CE/OE/WE/UB/LB and data-bus tristate timing from cycle counters. The PSRAM pins are driven only by this block. The 7-segment display and test logic sit on the requester side.

## Interface
- `ACCESS_CYC`, default 7: cycles WE#/OE# held low (70 ns at 100 MHz); legal range 1..15.
- `REC_CYC`, default 2: recovery cycles after each access, CE# high; legal range 1..15.
- `clk`  in  1  system clock; all logic on the rising edge.
- `clr`  in  1  reset, asynchronous, active-high.
- `req[1:0]`  in  2  per-port request level, held until `ack`.
- `wr[1:0]`  in  2  per-port 1 = write, 0 = read.
- `be0`, `be1`  in  2 each  byte enables, active-high: [1] = upper byte, [0] = lower byte.
- `addr0`, `addr1`  in  23 each  word address.
- `wdata0`, `wdata1`  in  16 each  write data.
- `ack[1:0]`  out  2  one-cycle pulse: request latched.
- `done[1:0]`  out  2  one-cycle pulse: access finished; `rdata` valid in the same cycle.
- `rdata`  out  16  read data, held until the next read completes.
- `ram_addr`  out  23; `ram_data`  inout  16.
- `ram_ce`, `ram_oe`, `ram_we`, `ram_ub`, `ram_lb`  out  1 each, active-low.
- `ram_adv`, `ram_cre`, `ram_clk`  out  1 each.

## Operation
- `ram_adv` = 0, `ram_cre` = 0, `ram_clk` = 0, constant (asynchronous mode). `ram_ub`/`ram_lb` = inverse of the latched byte enables.
- The FSM has four states: IDLE, SETUP, ACCESS, RECOVER.
- IDLE: if any `req` is high, the arbiter picks a port. The block latches that port's `wr`/`be`/`addr`/`wdata`, pulses that port's `ack`, and goes to SETUP.
- Arbitration: when both ports request, the port not served last wins. After reset, port 0 has priority.
- SETUP (1 cycle): `ram_addr` is driven, `ram_ce` = 0, `ram_oe` = `ram_we` = 1. For writes, `ram_data` is driven.
- ACCESS (`ACCESS_CYC` cycles): `ram_we` = 0 for writes, `ram_oe` = 0 for reads. On the last ACCESS edge, reads capture `ram_data` into `rdata`.
- RECOVER (`REC_CYC` cycles): `ram_we` = `ram_oe` = 1.
  - Write data and address stay driven in the first RECOVER cycle for hold time.
  - `ram_ce` = 1 for all RECOVER cycles.
  - `done` for the served port is pulsed in the last RECOVER cycle, then the FSM returns to IDLE.
- A wait counter, 4 bits wide, loads `ACCESS_CYC-1` or `REC_CYC-1` on state entry and counts down to 0.
- `ram_data` is driven only when the latched access is a write and the state is SETUP, ACCESS, or the first RECOVER cycle. Otherwise it is high-Z.
- Requests are never accepted outside IDLE. A `req` that drops before `ack` is simply not served.
- `be` = 2'b00 is a legal access: CE#/WE#/OE# still toggle and no byte changes.

## Timing
- Reset values:
  - `ram_ce` = `ram_oe` = `ram_we` = `ram_ub` = `ram_lb` = 1; `ram_addr` = 0; `ram_data` = Z.
  - `ack` = `done` = 0; `rdata` = 0; FSM = IDLE; round-robin pointer selects port 0.
- A request seen in IDLE at edge N produces `ack` high during cycle N+1 (registered).
- `done` rises `1 + ACCESS_CYC + REC_CYC` cycles after `ack`. The next IDLE grant can occur on the following edge.
- Back-to-back throughput: one access per `2 + ACCESS_CYC + REC_CYC` cycles (11 at defaults).
- `clr` asserted mid-access forces the reset values immediately (asynchronously). The aborted access produces no `done`.
- All pin outputs are registered; nothing combinational runs from `req` to the pins.

## Structure
- `psram_pkg` holds:
  - state encodings;
  - `PSRAM_AW` = 23 and `PSRAM_DW` = 16;
  - the idle pin levels.
- Sub-module `psram_rr_arb`: 2-way round-robin arbiter with inputs `req[1:0]` and `advance`, outputs `gnt_onehot[1:0]`, and its own last-served pointer.

## Test plan
- Port 0 writes 16'hAB03 to address 23'h000010 with `be` = 11, at defaults:
  - `ram_we` is low for exactly 7 cycles;
  - `ram_data` = AB03 from SETUP through the first RECOVER cycle;
  - `done[0]` occurs 10 cycles after `ack[0]`.
- Port 1 reads address 23'h000010; the PSRAM model returns AB03 → `rdata` = 16'hAB03 in the `done[1]` cycle, and `ram_data` stays high-Z throughout.
- Both ports request continuously for 4 accesses → grants go 0, 1, 0, 1, and consecutive `ack` pulses are 11 cycles apart.
- Port 0 write with `be` = 2'b01 → `ram_lb` = 0 and `ram_ub` = 1 during the access; the model keeps the upper byte.
- `clr` pulsed during ACCESS of a write:
  - `ram_we`/`ram_ce` go to 1 and `ram_data` goes to Z without waiting for a clock edge;
  - no `done` is produced;
  - the next request is granted to port 0.
- With `ACCESS_CYC` = 1 and `REC_CYC` = 1: a read completes with `done` 3 cycles after `ack`, and `ram_oe` is low for exactly 1 cycle.
